// File: rtl/imem_boot_ctrl_46.sv
// rtl/imem_boot_ctrl_46.sv - boot loader and write-port arbiter for the MIPS instruction memory
//
// Holds the processor in reset while a length-prefixed image arrives on a
// valid/ready word stream. Each image word is written to consecutive word
// addresses starting at BASE_ADDR. After the last write, processor reset stays
// asserted for RST_HOLD cycles. The instruction-memory write port is then
// handed to the processor.
//
// Ports:
//   clk_46, rst_46           clock, synchronous active-high reset
//   start_46                 one-cycle request to (re)start a load
//   ld_valid_46/ld_ready_46  loader handshake; ld_data_46 = length N, then N words
//   cpu_mw*_i_46             processor write port (used only in RUN)
//   mwa_i_46/mwd_i_46/mwr_i_46  write port to instruction memory
//   cpu_rst_46               processor reset
//   busy_46/done_46/err_46   status: loading / running / header rejected
module imem_boot_ctrl_46 #(
  parameter int          DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          RST_HOLD  = 4
) (
  input  logic        clk_46,
  input  logic        rst_46,
  input  logic        start_46,
  input  logic        ld_valid_46,
  input  logic [31:0] ld_data_46,
  output logic        ld_ready_46,
  input  logic [31:0] cpu_mwa_i_46,
  input  logic [31:0] cpu_mwd_i_46,
  input  logic        cpu_mwr_i_46,
  output logic [31:0] mwa_i_46,
  output logic [31:0] mwd_i_46,
  output logic        mwr_i_46,
  output logic        cpu_rst_46,
  output logic        busy_46,
  output logic        done_46,
  output logic        err_46
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int HW = $clog2(RST_HOLD + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_LOAD,
    S_HOLD,
    S_RUN,
    S_ERR
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic [CW-1:0] n_len;
  logic [CW-1:0] cnt;
  logic [31:0]   addr;
  logic [HW-1:0] hold_cnt;

  // Registered loader write, presented one cycle after its handshake.
  logic          wr_q;
  logic [31:0]   wa_q;
  logic [31:0]   wd_q;

  logic          ready;
  logic          hs;
  logic          hdr_bad;
  logic          last_word;

  assign ready       = (state == S_HDR) || (state == S_LOAD);
  assign ld_ready_46 = ready;
  assign hs          = ld_valid_46 && ready;
  assign hdr_bad     = (ld_data_46 == 32'd0) || (ld_data_46 > 32'(DEPTH));
  assign last_word   = (cnt + CW'(1)) == n_len;

  always_ff @(posedge clk_46) begin
    if (rst_46) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    busy_46    = 1'b0;
    done_46    = 1'b0;
    err_46     = 1'b0;
    cpu_rst_46 = 1'b1;
    case (state)
      S_IDLE: begin
        if (start_46) state_nxt = S_HDR;
      end
      S_HDR: begin
        busy_46 = 1'b1;
        if (hs) state_nxt = hdr_bad ? S_ERR : S_LOAD;
      end
      S_LOAD: begin
        busy_46 = 1'b1;
        if (hs && last_word) state_nxt = S_HOLD;
      end
      S_HOLD: begin
        busy_46 = 1'b1;
        if (hold_cnt == HW'(1)) state_nxt = S_RUN;
      end
      S_RUN: begin
        cpu_rst_46 = 1'b0;
        done_46    = 1'b1;
        if (start_46) state_nxt = S_HDR;
      end
      S_ERR: begin
        err_46 = 1'b1;
        if (start_46) state_nxt = S_HDR;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // The processor owns the write port only while RUN is the registered state,
  // so a restart request cuts the pass-through on the same edge that raises
  // cpu_rst_46.
  always_comb begin
    mwa_i_46 = wa_q;
    mwd_i_46 = wd_q;
    mwr_i_46 = wr_q;
    if (state == S_RUN) begin
      mwa_i_46 = cpu_mwa_i_46;
      mwd_i_46 = cpu_mwd_i_46;
      mwr_i_46 = cpu_mwr_i_46;
    end
  end

  always_ff @(posedge clk_46) begin
    if (rst_46) begin
      n_len    <= '0;
      cnt      <= '0;
      addr     <= '0;
      hold_cnt <= '0;
      wr_q     <= 1'b0;
      wa_q     <= '0;
      wd_q     <= '0;
    end else begin
      wr_q <= 1'b0;
      case (state)
        S_HDR: begin
          if (hs && !hdr_bad) begin
            // hdr_bad guarantees N <= DEPTH, so the narrowing is lossless.
            n_len <= ld_data_46[CW-1:0];
            cnt   <= '0;
            addr  <= BASE_ADDR;
          end
        end
        S_LOAD: begin
          if (hs) begin
            wr_q <= 1'b1;
            wa_q <= addr;
            wd_q <= ld_data_46;
            addr <= addr + 32'd4;
            cnt  <= cnt + CW'(1);
            if (last_word) hold_cnt <= HW'(RST_HOLD);
          end
        end
        S_HOLD: begin
          hold_cnt <= hold_cnt - HW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/imem_boot_ctrl_46.md
# imem_boot_ctrl_46

Boot sequencer and write-port arbiter for the instruction memory of the five-stage MIPS core. It holds the processor in reset, accepts a length-prefixed program image over a valid/ready word stream, and writes it into instruction memory at consecutive word addresses. It then releases processor reset after a fixed hold time and hands the instruction-memory write port back to the processor. It sits between the top level, the `proc` instruction-side write port (`mwa_i`/`mwd_i`/`mwr_i`) and `ins_mem_46`.

## Interface
- `DEPTH`, default 256: maximum image length in 32-bit words.
- `BASE_ADDR`, default 32'h0000_0000: byte address of the first image word. Must be word aligned.
- `RST_HOLD`, default 4: number of cycles processor reset stays asserted after the last image write. Must be at least 1.

- `clk_46`  in  1: single clock; all state changes on the rising edge.
- `rst_46`  in  1: reset, synchronous, active-high.
- `start_46`  in  1: single-cycle request to begin a boot/load sequence.
- `ld_valid_46`  in  1: loader word valid.
- `ld_data_46`  in  32: loader word. The first word of a sequence is the length N; the following N words are the image.
- `ld_ready_46`  out  1: block accepts a loader word this cycle.
- `cpu_mwa_i_46`  in  32: processor instruction-memory write address.
- `cpu_mwd_i_46`  in  32: processor instruction-memory write data.
- `cpu_mwr_i_46`  in  1: processor instruction-memory write enable.
- `mwa_i_46`  out  32: write address to instruction memory.
- `mwd_i_46`  out  32: write data to instruction memory.
- `mwr_i_46`  out  1: write enable to instruction memory.
- `cpu_rst_46`  out  1: reset to the processor, active-high.
- `busy_46`  out  1: a load sequence is in progress.
- `done_46`  out  1: the processor is running the loaded image.
- `err_46`  out  1: the last header was rejected.

## Operation
- States: IDLE, HDR, LOAD, HOLD, RUN, ERR.
- IDLE: `cpu_rst_46`=1, `ld_ready_46`=0.
  - `start_46` moves to HDR.
- HDR: `ld_ready_46`=1, `busy_46`=1. On a handshake, latch N.
  - N==0 or N>`DEPTH`: go to ERR. No write is issued.
  - Otherwise: clear the word counter, set the address to `BASE_ADDR`, go to LOAD.
- LOAD: `ld_ready_46`=1, `busy_46`=1. Each handshake registers a write of `ld_data_46` to the current address.
  - The address increments by 4; the counter increments by 1.
  - When the counter reaches N, go to HOLD and load the hold counter with `RST_HOLD`.
- HOLD: `busy_46`=1, `ld_ready_46`=0. The hold counter decrements each cycle. At 1, go to RUN.
- RUN: `cpu_rst_46`=0, `done_46`=1.
  - The instruction-memory write outputs are a combinational pass-through of `cpu_mwa_i_46`, `cpu_mwd_i_46` and `cpu_mwr_i_46`.
- ERR: `err_46`=1, `cpu_rst_46`=1.
  - `start_46` clears `err_46` and goes to HDR.
- Port ownership: in every state except RUN, the processor write inputs are ignored and `mwr_i_46` is driven only by the loader path.
- `start_46` in any of HDR, LOAD or HOLD: ignored.
- `start_46` in RUN: next state HDR.
  - `cpu_rst_46` rises on that edge and `done_46` falls.
  - The pass-through is cut from the same edge.
- A handshake occurs when `ld_valid_46` and `ld_ready_46` are both high at a rising edge. Words offered while `ld_ready_46`=0 are not consumed.
- Width rules:
  - Address arithmetic is 32-bit and wraps modulo 2^32. `DEPTH` bounds N, so there is no wrap in legal use.
  - The word counter is clog2(`DEPTH`+1) bits wide.

## Timing
- Reset values (the edge where `rst_46`=1):
  - State IDLE.
  - `cpu_rst_46`=1.
  - `ld_ready_46`=0, `mwr_i_46`=0, `mwa_i_46`=0, `mwd_i_46`=0.
  - `busy_46`=0, `done_46`=0, `err_46`=0.
  - Counters cleared.
- Reset mid-sequence aborts with no further writes. A pending registered write is dropped.
- `start_46` to `ld_ready_46`=1: 1 cycle.
- Handshake to `mwr_i_46` pulse: 1 cycle (registered). The pulse lasts exactly 1 cycle per accepted word.
  - Back-to-back handshakes give back-to-back write cycles.
- The write for the final word occurs in the first HOLD cycle.
- `cpu_rst_46` falls exactly `RST_HOLD` cycles after the final handshake edge. `done_46` rises on the same edge.
- The RUN pass-through has zero latency.

## Test plan
- **Normal load.** Start, then header 3, then 0x20080005, 0x20090003, 0x01095020 on consecutive cycles.
  - Writes go to addresses 0x0, 0x4, 0x8 on three consecutive cycles.
  - `cpu_rst_46` falls 4 cycles after the last handshake; `done_46`=1.
- **Backpressure/gaps.** Header 4 with `ld_valid_46` toggling 1,0,0,1,1,0,1 while data changes every cycle.
  - Exactly 4 writes occur, with only the words accepted by handshake, in order, at 0x0 to 0xC.
- **Bad headers.** Header 0, then on a separate run header 257 with `DEPTH`=256.
  - `err_46`=1, no `mwr_i_46` pulse, `cpu_rst_46` stays 1.
  - `start_46` then clears `err_46` and `ld_ready_46`=1 the next cycle.
- **RUN pass-through.** In RUN, drive `cpu_mwr_i_46`=1, `cpu_mwa_i_46`=0x40, `cpu_mwd_i_46`=0xDEADBEEF.
  - The same values appear on `mwa_i_46`/`mwd_i_46`/`mwr_i_46` in the same cycle.
  - The same stimulus in IDLE gives `mwr_i_46`=0.
- **Restart from RUN.** `start_46` during RUN.
  - Next cycle `cpu_rst_46`=1, `done_46`=0, `ld_ready_46`=1.
  - A new 2-word image is written at 0x0 and 0x4.
- **Reset mid-load.** `rst_46` pulse after 2 of 5 words.
  - All outputs take their reset values on that edge and no further writes occur.
  - The next `start_46` accepts a fresh header.
